// File: rtl/sram_dp_clr.sv
`default_nettype none
// ============================================================================
// Module      : sram_dp_clr
// Description : Dual-port byte-masked SRAM with mirror writes and a
//               self-clearing controller that zeroes the array after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_dp_clr #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int MIRROR_OFS = 3,
  parameter int OUT_REG    = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_ce,
  input  logic                    i_wr_en,
  input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_wr_be,
  input  logic                    i_wr_mirror,
  input  logic                    i_rd_en,
  input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_rd_valid,
  input  logic                    i_clr_start,
  output logic                    o_busy,
  output logic                    o_clr_done
);

  localparam int c_nb    = DATA_WIDTH / 8;
  localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_mofs  = MIRROR_OFS % DEPTH;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                r_state;
  logic [c_idx_w-1:0]    r_clr_cnt;
  logic                  r_clr_done;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_data;

  logic                  w_idle;
  logic                  w_wr_ok;
  logic                  w_mir_ok;
  logic                  w_rd_ok;
  logic                  w_rd_in_range;
  logic [c_idx_w-1:0]    w_wr_idx;
  logic [c_idx_w-1:0]    w_rd_idx;
  logic [c_idx_w-1:0]    w_mir_idx;
  logic [31:0]           w_mir_sum;

  assign w_idle        = (r_state == ST_IDLE);
  assign w_wr_idx      = i_wr_addr[c_idx_w-1:0];
  assign w_rd_idx      = i_rd_addr[c_idx_w-1:0];
  assign w_wr_ok       = w_idle && i_ce && i_wr_en && (32'(i_wr_addr) < 32'(DEPTH));
  assign w_rd_ok       = w_idle && i_ce && i_rd_en;
  assign w_rd_in_range = (32'(i_rd_addr) < 32'(DEPTH));
  // Wrap is a single subtraction because the base address is already < DEPTH.
  assign w_mir_sum     = 32'(w_wr_idx) + 32'(c_mofs);
  assign w_mir_idx     = c_idx_w'((w_mir_sum >= 32'(DEPTH)) ? (w_mir_sum - 32'(DEPTH)) : w_mir_sum);
  assign w_mir_ok      = w_wr_ok && i_wr_mirror && (c_mofs != 0);

  assign o_busy     = (r_state == ST_CLEAR);
  assign o_clr_done = r_clr_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_CLEAR;
      r_clr_cnt  <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_clr_done <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_cnt == c_idx_w'(DEPTH - 1)) begin
            r_state    <= ST_IDLE;
            r_clr_cnt  <= '0;
            r_clr_done <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          if (i_clr_start) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
          end
        end
      endcase
    end
  end

  // Array itself has no reset; the post-reset clear sweep zeroes it.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_ok) begin
      for (int k = 0; k < c_nb; k++) begin
        if (i_wr_be[k]) begin
          r_mem[w_wr_idx][8*k +: 8] <= i_wr_data[8*k +: 8];
          if (w_mir_ok) r_mem[w_mir_idx][8*k +: 8] <= i_wr_data[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else if (i_ce) begin
      r_s1_valid <= w_rd_ok;
      if (w_rd_ok) r_s1_data <= w_rd_in_range ? r_mem[w_rd_idx] : '0;
    end
  end

  generate
    if (OUT_REG == 1) begin : g_out_reg
      logic                  r_s2_valid;
      logic [DATA_WIDTH-1:0] r_s2_data;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else if (i_ce) begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) r_s2_data <= r_s1_data;
        end
      end

      assign o_rd_valid = r_s2_valid;
      assign o_rd_data  = r_s2_data;
    end else begin : g_no_out_reg
      assign o_rd_valid = r_s1_valid;
      assign o_rd_data  = r_s1_data;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sram_dp_clr.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_dp_clr
// Description : Directed vector bench for sram_dp_clr (DEPTH=16, OUT_REG=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_dp_clr;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_ce = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [4:0]  i_wr_addr = '0;
  logic [31:0] i_wr_data = '0;
  logic [3:0]  i_wr_be = '0;
  logic        i_wr_mirror = 1'b0;
  logic        i_rd_en = 1'b0;
  logic [4:0]  i_rd_addr = '0;
  logic [31:0] o_rd_data;
  logic        o_rd_valid;
  logic        i_clr_start = 1'b0;
  logic        o_busy;
  logic        o_clr_done;

  int n_cmp = 0;
  int n_bad = 0;

  sram_dp_clr #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(16), .MIRROR_OFS(3), .OUT_REG(1)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_wr_be(i_wr_be), .i_wr_mirror(i_wr_mirror),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .i_clr_start(i_clr_start), .o_busy(o_busy), .o_clr_done(o_clr_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        mir;
    logic        re;
    logic [4:0]  ra;
    logic        exp_v;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs [15];

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_wr_en = 1'b0; i_wr_mirror = 1'b0; i_rd_en = 1'b0; i_clr_start = 1'b0;
  endtask

  // One vector: drive for one cycle, then expect the read result two edges later.
  task automatic apply(input vec_t v, input int idx);
    i_ce = 1'b1;
    i_wr_en = v.we; i_wr_addr = v.wa; i_wr_data = v.wd; i_wr_be = v.be;
    i_wr_mirror = v.mir; i_rd_en = v.re; i_rd_addr = v.ra;
    step();
    idle_inputs();
    if (v.re) check($sformatf("vec%0d_early_valid", idx), 32'(o_rd_valid), 32'd0);
    step();
    check($sformatf("vec%0d_valid", idx), 32'(o_rd_valid), 32'(v.exp_v));
    if (v.exp_v) check($sformatf("vec%0d_data", idx), o_rd_data, v.exp_d);
  endtask

  task automatic count_clear(input string nm);
    int n = 0;
    while (o_busy && n < 100) begin
      step();
      n++;
    end
    check({nm, "_busy_cycles"}, 32'(n), 32'd16);
    check({nm, "_done_pulse"}, 32'(o_clr_done), 32'd1);
  endtask

  initial begin
    vec_t r;
    //          we    wa     wd             be       mir   re    ra     ev    ed
    vecs[0]  = '{1'b1, 5'd2,  32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 5'd2,  1'b1, 32'h00BB00DD};
    vecs[2]  = '{1'b1, 5'd14, 32'h12345678, 4'b1111, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 5'd14, 1'b1, 32'h12345678};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 5'd1,  1'b1, 32'h12345678};
    vecs[5]  = '{1'b1, 5'd5,  32'h1,        4'b1111, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0};
    vecs[6]  = '{1'b1, 5'd5,  32'h2,        4'b1111, 1'b0, 1'b1, 5'd5,  1'b1, 32'h1};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 5'd5,  1'b1, 32'h2};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 5'd20, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 5'd20, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 5'd4,  1'b1, 32'h0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 5'd7,  1'b1, 32'h0};
    vecs[12] = '{1'b1, 5'd15, 32'hFFFFFFFF, 4'b1000, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 5'd15, 1'b1, 32'hFF000000};
    vecs[14] = '{1'b0, 5'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 5'd2,  1'b1, 32'hFFBB00DD};

    // Asynchronous reset between clock edges.
    #2 i_rst = 1'b1;
    #1;
    check("rst_busy", 32'(o_busy), 32'd1);
    check("rst_valid", 32'(o_rd_valid), 32'd0);
    check("rst_data", o_rd_data, 32'd0);
    check("rst_done", 32'(o_clr_done), 32'd0);
    step();
    step();
    i_rst = 1'b0;
    count_clear("init");
    step();
    check("init_done_one_cycle", 32'(o_clr_done), 32'd0);

    for (int a = 0; a < 16; a++) begin
      r = '{1'b0, 5'd0, 32'h0, 4'b0, 1'b0, 1'b1, 5'(a), 1'b1, 32'h0};
      apply(r, 100 + a);
    end

    for (int i = 0; i < 15; i++) apply(vecs[i], i);

    // Freeze the pipeline with i_ce=0 while a read of address 15 is in flight.
    i_ce = 1'b1; i_rd_en = 1'b1; i_rd_addr = 5'd15;
    step();
    i_rd_en = 1'b0; i_ce = 1'b0;
    i_wr_en = 1'b1; i_wr_addr = 5'd3; i_wr_data = 32'h55555555; i_wr_be = 4'hF;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("freeze%0d_valid", c), 32'(o_rd_valid), 32'd0);
      check($sformatf("freeze%0d_data", c), o_rd_data, 32'hFFBB00DD);
    end
    i_wr_en = 1'b0; i_ce = 1'b1;
    step();
    check("unfreeze_valid", 32'(o_rd_valid), 32'd1);
    check("unfreeze_data", o_rd_data, 32'hFF000000);
    step();
    check("hold_valid", 32'(o_rd_valid), 32'd0);
    check("hold_data", o_rd_data, 32'hFF000000);
    r = '{1'b0, 5'd0, 32'h0, 4'b0, 1'b0, 1'b1, 5'd3, 1'b1, 32'h0};
    apply(r, 200);

    // User clear, interrupted by reset at clear cycle 7.
    i_clr_start = 1'b1;
    step();
    i_clr_start = 1'b0;
    check("clr_start_busy", 32'(o_busy), 32'd1);
    repeat (6) step();
    #2 i_rst = 1'b1;
    #1;
    check("midclr_rst_busy", 32'(o_busy), 32'd1);
    check("midclr_rst_data", o_rd_data, 32'd0);
    check("midclr_rst_valid", 32'(o_rd_valid), 32'd0);
    step();
    i_rst = 1'b0;
    begin
      int  n = 0;
      logic saw_v = 1'b0;
      while (o_busy && n < 100) begin
        if (n < 6) begin
          i_ce = 1'b1; i_clr_start = 1'b1;
          i_wr_en = 1'b1; i_wr_addr = 5'd0; i_wr_data = 32'hDEADBEEF; i_wr_be = 4'hF;
          i_rd_en = 1'b1; i_rd_addr = 5'd2;
        end else begin
          idle_inputs();
        end
        step();
        n++;
        if (o_rd_valid) saw_v = 1'b1;
      end
      check("reclr_busy_cycles", 32'(n), 32'd16);
      check("reclr_done_pulse", 32'(o_clr_done), 32'd1);
      check("reclr_no_read_valid", 32'(saw_v), 32'd0);
    end
    idle_inputs();
    step();
    check("reclr_not_restarted", 32'(o_busy), 32'd0);
    r = '{1'b0, 5'd0, 32'h0, 4'b0, 1'b0, 1'b1, 5'd0, 1'b1, 32'h0};
    apply(r, 300);
    r.ra = 5'd2;
    apply(r, 301);
    r.ra = 5'd15;
    apply(r, 302);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
